// File: rtl/chip8_call_return_unit_pkg.sv
// Shared types for the CHIP-8 CALL/RET sequencer: command and stack-op encodings,
// default timing parameters and the return-address helper.
package chip8_call_return_unit_pkg;

    typedef enum logic {
        CR_CALL = 1'b0,
        CR_RET  = 1'b1
    } CR_CMD;

    typedef enum logic [1:0] {
        STACK_HOLD = 2'd0,
        STACK_PUSH = 2'd1,
        STACK_POP  = 2'd2
    } STACK_OP;

    localparam int CR_DEPTH         = 16;
    localparam int CR_OP_CYCLES     = 2;
    localparam int CR_SETTLE_CYCLES = 2;
    // Phase counter width; OP_CYCLES and SETTLE_CYCLES must each be 1..16.
    localparam int CR_CNT_W         = 4;

    // Address of the instruction after a CALL, wrapping within the 12-bit space.
    function automatic logic [11:0] return_addr(input logic [11:0] pc);
        return pc + 12'd2;
    endfunction

endpackage

// File: rtl/chip8_call_return_unit.sv
// Sequencer between CPU decode and Chip8_Stack for CALL (2NNN) and RET (00EE):
// drives the stack op with hold/settle timing, tracks depth and returns the next PC.
module chip8_call_return_unit
    import chip8_call_return_unit_pkg::*;
#(
    parameter int DEPTH         = CR_DEPTH,
    parameter int OP_CYCLES     = CR_OP_CYCLES,
    parameter int SETTLE_CYCLES = CR_SETTLE_CYCLES
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cmd,
    input  logic [11:0] target_addr,
    input  logic [11:0] pc_in,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [11:0] pc_out,
    output logic [4:0]  depth,
    output logic [1:0]  stk_op,
    output logic [15:0] stk_writedata,
    input  logic [15:0] stk_outdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP,
        ST_SETTLE,
        ST_DONE,
        ST_FAULT
    } state_t;

    localparam logic [4:0]          DEPTH_MAX   = 5'(DEPTH);
    localparam logic [CR_CNT_W-1:0] OP_LOAD     = CR_CNT_W'(OP_CYCLES - 1);
    localparam logic [CR_CNT_W-1:0] SETTLE_LOAD = CR_CNT_W'(SETTLE_CYCLES - 1);

    state_t              state, state_next;
    logic [CR_CNT_W-1:0] cnt, cnt_next;
    logic                is_pop;
    logic [11:0]         pending_pc;
    logic                accept_call, accept_ret, reject;
    logic                unused_outdata_hi;

    assign unused_outdata_hi = ^stk_outdata[15:12];

    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // OP and SETTLE share one down-counter, reloaded on entry to each phase.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        accept_call = 1'b0;
        accept_ret  = 1'b0;
        reject      = 1'b0;
        busy        = (state != ST_IDLE);
        done        = 1'b0;
        fault       = 1'b0;
        stk_op      = STACK_HOLD;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cmd == CR_RET) begin
                        accept_ret = (depth != 5'd0);
                    end else begin
                        accept_call = (depth < DEPTH_MAX);
                    end
                    reject = !(accept_call || accept_ret);
                    if (reject) begin
                        state_next = ST_FAULT;
                    end else begin
                        state_next = ST_OP;
                        cnt_next   = OP_LOAD;
                    end
                end
            end
            ST_OP: begin
                stk_op = is_pop ? STACK_POP : STACK_PUSH;
                if (cnt == '0) begin
                    state_next = ST_SETTLE;
                    cnt_next   = SETTLE_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            ST_FAULT: begin
                done       = 1'b1;
                fault      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command inputs are captured only at accept; pc_out changes on the edge entering DONE/FAULT.
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            is_pop        <= 1'b0;
            pending_pc    <= 12'h000;
            pc_out        <= 12'h000;
            depth         <= 5'd0;
            stk_writedata <= 16'h0000;
        end else begin
            cnt <= cnt_next;
            if (accept_call) begin
                is_pop        <= 1'b0;
                pending_pc    <= target_addr;
                stk_writedata <= {4'h0, return_addr(pc_in)};
            end
            if (accept_ret) begin
                is_pop <= 1'b1;
            end
            if (reject) begin
                pc_out <= pc_in;
            end
            if (state == ST_OP && cnt == '0) begin
                depth <= is_pop ? depth - 5'd1 : depth + 5'd1;
            end
            if (state == ST_SETTLE && cnt == '0) begin
                pc_out <= is_pop ? stk_outdata[11:0] : pending_pc;
            end
        end
    end

endmodule

// File: tb/tb_chip8_call_return_unit.sv
// Randomised scoreboard bench for chip8_call_return_unit with a behavioural stack
// standing in for Chip8_Stack and a queue-based return-address reference model.
module tb_chip8_call_return_unit;
    import chip8_call_return_unit_pkg::*;

    localparam int OPC = CR_OP_CYCLES;
    localparam int STC = CR_SETTLE_CYCLES;

    typedef struct {
        logic        fault;
        logic [11:0] pc;
        logic [4:0]  depth;
        int          cyc;
        int          ops;
        logic        chk_wd;
        logic [15:0] wd;
    } exp_t;

    logic        cpu_clk = 1'b0;
    logic        reset   = 1'b0;
    logic        start   = 1'b0;
    logic        cmd     = CR_CALL;
    logic [11:0] target_addr = 12'h000;
    logic [11:0] pc_in       = 12'h000;
    logic        busy, done, fault;
    logic [11:0] pc_out;
    logic [4:0]  depth;
    logic [1:0]  stk_op;
    logic [15:0] stk_writedata;
    logic [15:0] stk_outdata;

    exp_t        sb[$];
    logic [11:0] mstk[$];
    logic [15:0] emu[$];
    logic [1:0]  emu_prev;
    int          cyc = 0;
    int          timeouts = 0;
    bit          end_req = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          op_cnt = 0;
    logic [1:0]  prev_op = STACK_HOLD;
    logic [15:0] wd_seen = 16'h0;

    chip8_call_return_unit dut (
        .cpu_clk      (cpu_clk),
        .reset        (reset),
        .start        (start),
        .cmd          (cmd),
        .target_addr  (target_addr),
        .pc_in        (pc_in),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .pc_out       (pc_out),
        .depth        (depth),
        .stk_op       (stk_op),
        .stk_writedata(stk_writedata),
        .stk_outdata  (stk_outdata)
    );

    always #20 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) cyc <= cyc + 1;

    // Stand-in for Chip8_Stack: one push/pop per op burst, popped word presented on outdata.
    always @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            emu.delete();
            emu_prev    <= STACK_HOLD;
            stk_outdata <= 16'h0000;
        end else begin
            if (stk_op == STACK_PUSH && emu_prev != STACK_PUSH) emu.push_back(stk_writedata);
            if (stk_op == STACK_POP && emu_prev != STACK_POP && emu.size() > 0) begin
                stk_outdata <= emu[$];
                emu.pop_back();
            end
            emu_prev <= stk_op;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: reset values, op-burst shape, and scoreboard comparison at every done.
    always @(negedge cpu_clk) begin
        if (!reset) begin
            checkOutput("rst_busy", 32'(busy), 0);
            checkOutput("rst_done", 32'(done), 0);
            checkOutput("rst_fault", 32'(fault), 0);
            checkOutput("rst_pc_out", 32'(pc_out), 0);
            checkOutput("rst_depth", 32'(depth), 0);
            checkOutput("rst_stk_op", 32'(stk_op), 32'(STACK_HOLD));
            checkOutput("rst_writedata", 32'(stk_writedata), 0);
            sb.delete();
            op_cnt  = 0;
            prev_op = STACK_HOLD;
        end else begin
            checkOutput("fault_qualified", 32'(fault & ~done), 0);
            if (stk_op != STACK_HOLD) begin
                op_cnt++;
                if (stk_op == STACK_PUSH) wd_seen = stk_writedata;
                if (prev_op != STACK_HOLD) checkOutput("op_no_flip", 32'(stk_op), 32'(prev_op));
            end
            prev_op = stk_op;
            if (done) begin
                checkOutput("done_expected", 32'(sb.size() != 0), 1);
                checkOutput("busy_at_done", 32'(busy), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("fault", 32'(fault), 32'(e.fault));
                    checkOutput("pc_out", 32'(pc_out), 32'(e.pc));
                    checkOutput("depth", 32'(depth), 32'(e.depth));
                    checkOutput("done_cycle", cyc, e.cyc);
                    checkOutput("op_cycles", op_cnt, e.ops);
                    if (e.chk_wd) checkOutput("writedata", 32'(wd_seen), 32'(e.wd));
                end
                op_cnt = 0;
            end
            if (end_req) begin
                checkOutput("sb_drained", sb.size(), 0);
                checkOutput("no_timeouts", timeouts, 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    task automatic waitIdle();
        int guard = 0;
        @(negedge cpu_clk);
        while (busy && guard < 60) begin
            @(negedge cpu_clk);
            guard++;
        end
        if (guard >= 60) timeouts++;
    endtask

    // Issue one command, predict its response, then optionally poke start while busy.
    task automatic applyStimulus(input logic c, input logic [11:0] pc, input logic [11:0] tgt,
                                 input bit junk);
        exp_t        e;
        logic [11:0] ret;
        waitIdle();
        e.ops = 0;
        e.chk_wd = 1'b0;
        e.wd = 16'h0;
        e.fault = 1'b0;
        if (c == CR_CALL) begin
            if (mstk.size() >= 16) begin
                e.fault = 1'b1;
                e.pc    = pc;
            end else begin
                ret = pc + 12'd2;
                mstk.push_back(ret);
                e.pc     = tgt;
                e.ops    = OPC;
                e.chk_wd = 1'b1;
                e.wd     = {4'h0, ret};
            end
        end else begin
            if (mstk.size() == 0) begin
                e.fault = 1'b1;
                e.pc    = pc;
            end else begin
                e.pc  = mstk.pop_back();
                e.ops = OPC;
            end
        end
        e.depth = 5'(mstk.size());
        e.cyc   = cyc + 1 + (e.fault ? 0 : OPC + STC);
        sb.push_back(e);
        start = 1'b1;
        cmd = c;
        pc_in = pc;
        target_addr = tgt;
        @(negedge cpu_clk);
        start = junk;
        cmd = 1'($urandom);
        pc_in = 12'($urandom);
        target_addr = 12'($urandom);
        @(negedge cpu_clk);
        start = 1'b0;
    endtask

    initial begin
        #(40 * 60000);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #90 reset = 1'b1;

        applyStimulus(CR_CALL, 12'h200, 12'h300, 1'b0);
        applyStimulus(CR_RET, 12'h310, 12'h000, 1'b1);

        applyStimulus(CR_CALL, 12'h200, 12'h400, 1'b0);
        applyStimulus(CR_CALL, 12'h400, 12'h600, 1'b1);
        applyStimulus(CR_CALL, 12'h600, 12'h800, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(CR_RET, 12'($urandom), 12'h000, 1'b0);

        applyStimulus(CR_RET, 12'h123, 12'h456, 1'b1);

        for (int i = 0; i < 17; i++) applyStimulus(CR_CALL, 12'($urandom), 12'($urandom), 1'b0);
        applyStimulus(CR_RET, 12'h0A0, 12'h000, 1'b0);
        applyStimulus(CR_CALL, 12'hFFE, 12'h222, 1'b0);
        applyStimulus(CR_RET, 12'h222, 12'h000, 1'b0);

        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'($urandom), 12'($urandom), 12'($urandom), 1'($urandom));
        end

        // Reset just after an accepted CALL: the push must be abandoned before the next edge.
        waitIdle();
        start = 1'b1;
        cmd = CR_CALL;
        pc_in = 12'h345;
        target_addr = 12'h678;
        @(posedge cpu_clk);
        #5 reset = 1'b0;
        start = 1'b0;
        mstk.delete();
        repeat (2) @(negedge cpu_clk);
        #5 reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom), 12'($urandom), 12'($urandom), 1'($urandom));
        end

        waitIdle();
        repeat (3) @(negedge cpu_clk);
        #5 end_req = 1'b1;
    end

endmodule
